// File: rtl/fetch_req_queue.sv
// Purpose : buffers pcgen fetch bundles and expands each into NUM_OF_FETCH sequential icache requests.
// Latency : a pushed bundle is presented at the request port one cycle after the push (no bypass).
// Backpr. : req_ready low holds the request stable; stall_out tells pcgen to stop with one slot kept in reserve.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high
//   pc_in        in   pc_t bundle from pcgen {valid, vaddr, first_instr_id}
//   flush_in     in   addr_with_valid_t redirect; only .valid is used here
//   stall_out    out  registered-count based stall to pcgen
//   req_valid    out  icache request valid
//   req_vaddr    out  request address (head.vaddr + 4*sub, wraps)
//   req_instr_id out  request id (head.first_instr_id + sub, wraps)
//   req_ready    in   icache accepts the current request
//   overflow_out out  sticky: a bundle was dropped because the queue was full

package fetch_req_queue_pkg;

   localparam int VADDR_WIDTH = 39;

   typedef struct packed {
      logic                   valid;
      logic [VADDR_WIDTH-1:0] vaddr;
      logic [31:0]            first_instr_id;
   } pc_t;

   typedef struct packed {
      logic                   valid;
      logic [VADDR_WIDTH-1:0] addr;
   } addr_with_valid_t;

endpackage

module fetch_req_queue
   import fetch_req_queue_pkg::*;
#(
   parameter int DEPTH        = 8,   // power of two, >= 2
   parameter int NUM_OF_FETCH = 3    // 1..4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  pc_t                    pc_in,
   input  addr_with_valid_t       flush_in,
   output logic                   stall_out,
   output logic                   req_valid,
   output logic [VADDR_WIDTH-1:0] req_vaddr,
   output logic [31:0]            req_instr_id,
   input  logic                   req_ready,
   output logic                   overflow_out
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SUB_W = (NUM_OF_FETCH > 1) ? $clog2(NUM_OF_FETCH) : 1;

   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);
   localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(NUM_OF_FETCH - 1);

   typedef struct packed {
      logic [VADDR_WIDTH-1:0] vaddr;
      logic [31:0]            first_instr_id;
   } entry_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   entry_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic [SUB_W-1:0]   sub_q,    sub_d;
   logic               overflow_q, overflow_d;

   // ------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------
   entry_t head;
   logic   flush;
   logic   handshake;
   logic   last_sub;
   logic   pop;
   logic   push_req;
   logic   push;
   logic   full;

   // Only the redirect's valid bit matters here; the target address is
   // consumed by pcgen.
   logic unused_flush_addr;
   assign unused_flush_addr = ^flush_in.addr;

   assign head      = mem_q[rd_ptr_q];
   assign flush     = flush_in.valid;
   assign full      = (count_q == CNT_FULL);
   assign last_sub  = (sub_q == SUB_LAST);

   // A flush voids any request in its cycle, so the handshake can never
   // pop an entry that the flush is about to discard anyway.
   assign req_valid = (count_q != '0) && !flush;
   assign handshake = req_valid && req_ready;
   assign pop       = handshake && last_sub;

   // Bundles arriving with a flush are stale; bundles arriving at full are
   // accepted only when the head leaves in the same cycle.
   assign push_req  = pc_in.valid && !flush;
   assign push      = push_req && (!full || pop);

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // One slot is held in reserve because pcgen samples stall a cycle late.
   assign stall_out    = (count_q >= CNT_STALL);
   assign req_vaddr    = head.vaddr + VADDR_WIDTH'({sub_q, 2'b00});
   assign req_instr_id = head.first_instr_id + 32'(sub_q);
   assign overflow_out = overflow_q;

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      sub_d      = sub_q;
      overflow_d = overflow_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         sub_d    = '0;
      end else begin
         // Sub-index walks 0..N-1 per bundle, advancing only on a handshake.
         if (handshake) begin
            sub_d = last_sub ? '0 : sub_q + SUB_W'(1);
         end

         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end

         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase

         if (push_req && !push) begin
            overflow_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         sub_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         sub_q      <= sub_d;
         overflow_q <= overflow_d;
      end
   end

   // Payload storage needs no reset: nothing reads it while count is zero.
   // At full with a simultaneous pop the write lands in the slot being
   // vacated, which is safe because the head is read combinationally.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{vaddr: pc_in.vaddr, first_instr_id: pc_in.first_instr_id};
      end
   end

   // ------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------
   a_count_bound : assert property (@(posedge clock) disable iff (reset)
      count_q <= CNT_FULL);

   a_sub_bound : assert property (@(posedge clock) disable iff (reset)
      sub_q <= SUB_LAST);

   a_req_stable : assert property (@(posedge clock) disable iff (reset)
      (req_valid && !req_ready && !$past(reset) ##1 !flush && !reset)
         |-> ($stable(req_vaddr) && $stable(req_instr_id)));

endmodule
